ram_readback_seq: RTL and testbench

//  Reader side of the sequence-generator datapath: after the write controller has filled the data RAM,

---
 rtl/cod_pkg.sv | 6 +
 rtl/seq_check.sv | 42 ++++
 rtl/ram_readback_seq.sv | 99 +++++++++
 tb/tb_ram_readback_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cod_pkg.sv
// cod_pkg: shared FSM state encoding and default RAM geometry for the sequence-generator datapath
package cod_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;
    localparam int COD_ADDR_W = 6;
    localparam int COD_DATA_W = 32;
endpackage

// File: rtl/seq_check.sv
// seq_check: verifies each read-back word follows word[i] = word[i-1] + word[i-2] mod 2^DATA_W
//  clk, rst        clock, synchronous active-high reset
//  clr             accepted start; clears history and error
//  cap             a word is being captured this cycle
//  data, addr      captured word and its RAM address
//  err, err_addr   sticky mismatch flag and first failing address
module seq_check #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cap,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    logic [DATA_W-1:0] h1, h2;
    logic [1:0] n;
    logic mis;
    // n counts captured words up to 2; the recurrence only applies once two predecessors exist
    assign mis = (n == 2'd2) && (data != DATA_W'(h1 + h2));
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            h1       <= '0;
            h2       <= '0;
            n        <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else if (cap) begin
            h2 <= h1;
            h1 <= data;
            n  <= (n == 2'd2) ? n : n + 2'd1;
            if (mis && !err) begin
                err      <= 1'b1;
                err_addr <= addr;
            end
        end
    end
endmodule

// File: rtl/ram_readback_seq.sv
// ram_readback_seq: scans a RAM address window and streams each word out on a valid/ready port
//  clk, rst              clock, synchronous active-high reset
//  start                 begin a scan (accepted only when idle)
//  busy, done            scan in progress / one-cycle completion pulse
//  ram_addr, ram_dout    RAM read address (registered) and data (1-cycle latency)
//  out_data, out_addr    streamed word and its source address
//  out_valid, out_ready  stream handshake
//  err, err_addr         sequence-check failure and first failing address
// Optional: define READBACK_CHECK_EN to build the Fibonacci-recurrence checker; otherwise err/err_addr are 0.
module ram_readback_seq
    import cod_pkg::*;
#(
    parameter int                ADDR_W     = COD_ADDR_W,
    parameter int                DATA_W     = COD_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                COUNT      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int CNT_W = $clog2(COUNT + 1);
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic accept, cap, xfer, last;
    assign accept = (state == IDLE) && start;
    assign cap    = (state == WAIT);
    assign xfer   = (state == HOLD) && out_valid && out_ready;
    // the word counter, not the address, decides the end so the address may wrap mid-scan
    assign last   = (cnt == CNT_W'(COUNT - 1));
    assign busy   = (state == ISSUE) || (state == WAIT) || (state == HOLD);
    assign done   = (state == DONE);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = HOLD;
            HOLD:    nxt = xfer ? (last ? DONE : ISSUE) : HOLD;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_addr  <= START_ADDR;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            state <= nxt;
            if (cap) begin
                out_data  <= ram_dout;
                out_addr  <= ram_addr;
                out_valid <= 1'b1;
            end
            if (xfer) begin
                out_valid <= 1'b0;
                if (!last) begin
                    ram_addr <= ADDR_W'(ram_addr + 1'b1);
                    cnt      <= CNT_W'(cnt + 1'b1);
                end
            end
            if (state == DONE) begin
                ram_addr <= START_ADDR;
                cnt      <= '0;
            end
        end
    end
`ifdef READBACK_CHECK_EN
    seq_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .cap      (cap),
        .data     (ram_dout),
        .addr     (ram_addr),
        .err      (err),
        .err_addr (err_addr)
    );
`else
    assign err      = 1'b0;
    assign err_addr = '0;
    logic unused;
    assign unused = accept;
`endif
endmodule

// File: tb/tb_ram_readback_seq.sv
// tb_ram_readback_seq: randomized and directed checks of ram_readback_seq against a behavioural model
module tb_ram_readback_seq;
    localparam int AW = 6;
    localparam int DW = 32;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic busy, done, out_valid, err;
    logic [AW-1:0] ram_addr, out_addr, err_addr;
    logic [DW-1:0] ram_dout, out_data;
    logic start2 = 1'b0, out_ready2 = 1'b1;
    logic busy2, done2, out_valid2, err2;
    logic [AW-1:0] ram_addr2, out_addr2, err_addr2;
    logic [DW-1:0] ram_dout2, out_data2;
    logic [DW-1:0] mem [64];
    int total = 0, bad = 0, dones = 0, nx = 0;
    bit fib = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ram_dout <= mem[ram_addr];
    always @(posedge clk) ram_dout2 <= mem[ram_addr2];
    ram_readback_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .err(err), .err_addr(err_addr)
    );
    ram_readback_seq #(.START_ADDR(6'd62), .COUNT(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .ram_addr(ram_addr2), .ram_dout(ram_dout2), .out_data(out_data2), .out_addr(out_addr2),
        .out_valid(out_valid2), .out_ready(out_ready2), .err(err2), .err_addr(err_addr2)
    );
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            tick;
            k++;
        end
        chk("done_reached", done, 1);
    endtask
    task automatic load_fib(input logic [DW-1:0] a0, input logic [DW-1:0] a1);
        mem[0] = a0;
        mem[1] = a1;
        for (int i = 2; i < 64; i++) mem[i] = DW'(mem[i-1] + mem[i-2]);
    endtask
    task automatic go;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask
    initial begin
        fork
            begin : compare
                logic pv, pr, pbusy, mdl_err;
                logic [DW-1:0] pd;
                logic [AW-1:0] pa, a, a1, a2, mdl_ea;
                pv = 0; pr = 0; pbusy = 0; mdl_err = 0; mdl_ea = '0; pd = '0; pa = '0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        nx = 0; mdl_err = 0; mdl_ea = '0; pv = 0; pbusy = 0;
                    end else begin
                        if (busy && !pbusy) begin
                            chk("err_clear_on_start", err, 0);
                            chk("err_addr_clear_on_start", err_addr, 0);
                            nx = 0; mdl_err = 0; mdl_ea = '0;
                        end
                        if (pv && !pr) begin
                            chk("hold_valid", out_valid, 1);
                            chk("hold_data", out_data, pd);
                            chk("hold_addr", out_addr, pa);
                        end
                        if (done) begin
                            chk("done_word_count", nx, 30);
                            chk("done_busy_low", busy, 0);
                            dones++;
                        end
                        if (out_valid) chk("valid_implies_busy", busy, 1);
                        if (out_valid && out_ready) begin
                            a = AW'(nx);
                            a1 = AW'(nx - 1);
                            a2 = AW'(nx - 2);
                            chk("xfer_addr", out_addr, a);
                            chk("xfer_data", out_data, mem[a]);
                            if (fib && a == 7) chk("pin_word7", out_data, 21);
                            if (fib && a == 29) chk("pin_word29", out_data, 832040);
`ifdef READBACK_CHECK_EN
                            if (nx >= 2 && !mdl_err && mem[a] != DW'(mem[a1] + mem[a2])) begin
                                mdl_err = 1;
                                mdl_ea = a;
                            end
`endif
                            chk("err", err, mdl_err);
                            chk("err_addr", err_addr, mdl_ea);
                            nx++;
                        end
                        pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pbusy = busy;
                    end
                end
            end
            begin : drive
                int cyc, k, stall, d0, n;
                logic [AW-1:0] e [4];
                e = '{6'd62, 6'd63, 6'd0, 6'd1};
                load_fib(32'd1, 32'd1);
                fib = 1;
                repeat (2) tick;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_err", err, 0);
                chk("rst_err_addr", err_addr, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_ram_addr2", ram_addr2, 62);
                rst = 1'b0;
                tick;
                // full scan, ready held high, latency and single done
                out_ready = 1'b1;
                d0 = dones;
                go;
                chk("busy_after_accept", busy, 1);
                cyc = 1;
                while (!out_valid && cyc < 10) begin
                    tick;
                    cyc++;
                end
                chk("first_valid_latency", cyc, 3);
                wait_done(500);
                repeat (4) tick;
                chk("single_done", dones - d0, 1);
                chk("idle_ram_addr", ram_addr, 0);
                // stall on word 7 for five cycles
                go;
                stall = 0;
                k = 0;
                while (!done && k < 500) begin
                    if (out_valid && out_addr == 7 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                        chk("stall_data", out_data, 21);
                        chk("stall_addr", out_addr, 7);
                    end else out_ready = 1'b1;
                    tick;
                    k++;
                end
                chk("stall_cycles", stall, 5);
                chk("done_after_stall", done, 1);
                repeat (3) tick;
                // reset while holding word 10
                go;
                k = 0;
                while (!(out_valid && out_addr == 10) && k < 200) begin
                    out_ready = 1'b1;
                    tick;
                    k++;
                end
                out_ready = 1'b0;
                chk("reached_addr10", out_addr, 10);
                d0 = dones;
                rst = 1'b1;
                tick;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_ram_addr", ram_addr, 0);
                rst = 1'b0;
                repeat (4) tick;
                chk("abort_no_done", dones - d0, 0);
                out_ready = 1'b1;
                go;
                wait_done(500);
                repeat (2) tick;
                // starts while busy and during DONE are ignored
                d0 = dones;
                go;
                k = 0;
                while (!done && k < 2000) begin
                    start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                    tick;
                    k++;
                end
                chk("done_reached_busy_starts", done, 1);
                start = 1'b1;
                tick;
                start = 1'b0;
                repeat (5) tick;
                chk("ignored_starts_busy", busy, 0);
                chk("ignored_starts_one_done", dones - d0, 1);
                // randomized contents and backpressure
                fib = 0;
                for (int r = 0; r < 4; r++) begin
                    load_fib($urandom, $urandom);
                    if (r[0]) mem[$urandom_range(0, 29)] = $urandom;
                    go;
                    k = 0;
                    while (!done && k < 2000) begin
                        out_ready = 1'($urandom_range(0, 1));
                        tick;
                        k++;
                    end
                    chk("rand_done", done, 1);
                    repeat ($urandom_range(1, 4)) tick;
                end
                // corrupted word 12
                load_fib(32'd1, 32'd1);
                fib = 1;
                mem[12] = '0;
                out_ready = 1'b1;
                go;
                wait_done(500);
                tick;
`ifdef READBACK_CHECK_EN
                chk("corrupt_err", err, 1);
                chk("corrupt_err_addr", err_addr, 12);
`else
                chk("corrupt_err_tied", err, 0);
                chk("corrupt_err_addr_tied", err_addr, 0);
`endif
                go;
                wait_done(500);
                mem[12] = 32'd233;
                repeat (2) tick;
                // wrapping window on the second instance
                out_ready2 = 1'b1;
                start2 = 1'b1;
                tick;
                start2 = 1'b0;
                n = 0;
                k = 0;
                while (k < 100) begin
                    @(negedge clk);
                    if (done2) break;
                    if (out_valid2 && out_ready2) begin
                        chk("wrap_addr", out_addr2, e[n[1:0]]);
                        chk("wrap_data", out_data2, mem[e[n[1:0]]]);
                        n++;
                    end
                    k++;
                end
                chk("wrap_done", done2, 1);
                chk("wrap_words", n, 4);
                chk("wrap_done_busy", busy2, 0);
                tick;
                chk("wrap_idle_addr", ram_addr2, 62);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end
endmodule
